key_select_ctrl: RTL and testbench

//   Upstream control stage for the 7-bit A/B switch selector on the DE2 board.

---
 rtl/key_select_ctrl_pkg.sv | 22 ++
 rtl/key_select_ctrl_sync2.sv | 23 ++
 rtl/key_select_ctrl.sv | 128 ++++++++++++
 tb/tb_key_select_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/key_select_ctrl_pkg.sv
// Shared types and defaults for the KEY[3] A/B select control stage.
package sel_pkg;

    localparam int unsigned SEL_WIDTH_DEF = 7;
    localparam int unsigned DEBOUNCE_DEF  = 500000;
    localparam int unsigned REPEAT_DEF    = 25000000;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } sel_state_t;

    // Counter width large enough to hold max(a, b) - 1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/key_select_ctrl_sync2.sv
// Generic two-flop synchroniser with a configurable reset value.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_select_ctrl.sv
// Debounced KEY[3] press toggles the A/B select, strobes, and captures the chosen operand.
// Optional auto-repeat while held is enabled by defining SEL_AUTO_REPEAT_EN.
module key_select_ctrl
    import sel_pkg::*;
#(
    parameter int unsigned WIDTH           = SEL_WIDTH_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_DEF
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             KEY_N,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             SEL,
    output logic             SEL_PULSE,
    output logic [WIDTH-1:0] DATA_Q,
    output logic             VALID
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    sel_state_t    state;
    logic [CW-1:0] cnt;
    logic          k_s;
    logic          fire;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (CLOCK_50),
        .rst (RESET),
        .d   (KEY_N),
        .q   (k_s)
    );

`ifdef SEL_AUTO_REPEAT_EN
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_CYCLES - 1);
    logic [CW-1:0] rpt;

    always_comb begin
        fire = 1'b0;
        if (state == PRESS_CHK && !k_s && cnt == DB_LAST)
            fire = 1'b1;
        if (state == PRESSED && !k_s && rpt == RP_LAST)
            fire = 1'b1;
    end

    // Survives PRESSED<->RELEASE_CHK bounces; only a completed release clears it.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            rpt <= '0;
        end else if (state == PRESSED && !k_s) begin
            rpt <= (rpt == RP_LAST) ? '0 : rpt + 1'b1;
        end else if (state == RELEASE_CHK && k_s && cnt == DB_LAST) begin
            rpt <= '0;
        end
    end
`else
    always_comb begin
        fire = 1'b0;
        if (state == PRESS_CHK && !k_s && cnt == DB_LAST)
            fire = 1'b1;
    end
`endif

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state     <= RELEASED;
            cnt       <= '0;
            SEL       <= 1'b0;
            SEL_PULSE <= 1'b0;
            DATA_Q    <= '0;
            VALID     <= 1'b0;
        end else begin
            SEL_PULSE <= 1'b0;

            case (state)
                RELEASED: begin
                    if (!k_s) begin
                        state <= PRESS_CHK;
                        cnt   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (k_s) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (k_s) begin
                        state <= RELEASE_CHK;
                        cnt   <= '0;
                    end
                end
                RELEASE_CHK: begin
                    if (!k_s) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase

            // Operand follows the new select: old SEL=0 selects B.
            if (fire) begin
                SEL       <= ~SEL;
                SEL_PULSE <= 1'b1;
                DATA_Q    <= SEL ? A : B;
                VALID     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_select_ctrl.sv
// Directed bench for key_select_ctrl with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, WIDTH=7.
module tb_key_select_ctrl;

    localparam int unsigned W  = 7;
    localparam int unsigned DB = 4;
    localparam int unsigned RP = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sel;
    logic         sel_pulse;
    logic [W-1:0] data_q;
    logic         valid;

    int unsigned errors    = 0;
    int unsigned checks    = 0;
    int unsigned cyc       = 0;
    int unsigned t0        = 0;
    int unsigned pulses    = 0;
    int unsigned first_off = 0;
    int unsigned last_off  = 0;

    key_select_ctrl #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_CYCLES   (RP)
    ) dut (
        .CLOCK_50  (clk),
        .RESET     (rst),
        .KEY_N     (key_n),
        .A         (a),
        .B         (b),
        .SEL       (sel),
        .SEL_PULSE (sel_pulse),
        .DATA_Q    (data_q),
        .VALID     (valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Offsets count rising edges since the key edge that started the sequence.
    always @(negedge clk) begin
        if (sel_pulse) begin
            if (pulses == 0) first_off = cyc - t0;
            last_off = cyc - t0;
            pulses = pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic key(input logic lvl, input int n);
        key_n = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic start_seq();
        pulses = 0;
        t0     = cyc;
    endtask

    initial begin
        rst   = 1'b1;
        key_n = 1'b0;
        a     = '0;
        b     = '0;

        // Reset held with the key pressed
        repeat (6) @(negedge clk);
        check("rst_sel",    32'(sel),       32'd0);
        check("rst_pulse",  32'(sel_pulse), 32'd0);
        check("rst_data",   32'(data_q),    32'd0);
        check("rst_valid",  32'(valid),     32'd0);
        check("rst_npulse", pulses,         32'd0);
        key_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Clean press: strobe 7 edges after the fall, B captured
        a = 7'h15; b = 7'h6A;
        start_seq();
        key(1'b0, 10);
        check("p1_first", first_off,       32'd7);
        check("p1_count", pulses,          32'd1);
        check("p1_sel",   32'(sel),        32'd1);
        check("p1_data",  32'(data_q),     32'h6A);
        check("p1_valid", 32'(valid),      32'd1);
        key(1'b0, 2);
        key(1'b1, 12);
        check("p1_total", pulses, 32'd1);

        // Switches changing between presses leave the capture alone
        a = 7'h22; b = 7'h11;
        repeat (3) @(negedge clk);
        check("hold_data", 32'(data_q), 32'h6A);
        check("hold_sel",  32'(sel),    32'd1);

        // Short glitch rejected
        a = 7'h15; b = 7'h6A;
        start_seq();
        key(1'b0, 3);
        key(1'b1, 12);
        check("gl_count", pulses,      32'd0);
        check("gl_sel",   32'(sel),    32'd1);
        check("gl_data",  32'(data_q), 32'h6A);

        // Second press selects A
        b = 7'h40;
        start_seq();
        key(1'b0, 12);
        key(1'b1, 12);
        check("p2_count", pulses,      32'd1);
        check("p2_first", first_off,   32'd7);
        check("p2_sel",   32'(sel),    32'd0);
        check("p2_data",  32'(data_q), 32'h15);

        // Release bounces (2 and 3 high cycles) never re-arm the press
        b = 7'h2B;
        start_seq();
        key(1'b0, 6);
        key(1'b1, 2);
        key(1'b0, 4);
        key(1'b1, 3);
        key(1'b0, 3);
        key(1'b1, 12);
        check("bn_count", pulses,      32'd1);
        check("bn_sel",   32'(sel),    32'd1);
        check("bn_data",  32'(data_q), 32'h2B);

        start_seq();
        key(1'b0, 12);
        key(1'b1, 12);
        check("bn_next_count", pulses,      32'd1);
        check("bn_next_first", first_off,   32'd7);
        check("bn_next_sel",   32'(sel),    32'd0);
        check("bn_next_data",  32'(data_q), 32'h15);

        // Long hold
        a = 7'h3C; b = 7'h5A;
        start_seq();
        key(1'b0, 40);
        key(1'b1, 12);
`ifdef SEL_AUTO_REPEAT_EN
        check("hold40_count", pulses,   32'd5);
        check("hold40_last",  last_off, 32'd39);
`else
        check("hold40_count", pulses,   32'd1);
        check("hold40_last",  last_off, 32'd7);
`endif
        check("hold40_sel",  32'(sel),    32'd1);
        check("hold40_data", 32'(data_q), 32'h5A);

        // Reset in the middle of a hold
        start_seq();
        key(1'b0, 10);
        rst    = 1'b1;
        pulses = 0;
        repeat (2) @(negedge clk);
        check("mh_sel",   32'(sel),       32'd0);
        check("mh_pulse", 32'(sel_pulse), 32'd0);
        check("mh_data",  32'(data_q),    32'd0);
        check("mh_valid", 32'(valid),     32'd0);
        key_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("mh_count", pulses,     32'd0);
        check("mh_valid_after", 32'(valid), 32'd0);

        // Reset in the middle of the press debounce
        start_seq();
        key(1'b0, 5);
        rst = 1'b1;
        @(negedge clk);
        key_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("md_count", pulses,     32'd0);
        check("md_sel",   32'(sel),   32'd0);
        check("md_valid", 32'(valid), 32'd0);

        // Normal operation resumes after reset
        a = 7'h15; b = 7'h6A;
        start_seq();
        key(1'b0, 12);
        key(1'b1, 12);
        check("post_count", pulses,      32'd1);
        check("post_first", first_off,   32'd7);
        check("post_sel",   32'(sel),    32'd1);
        check("post_data",  32'(data_q), 32'h6A);
        check("post_valid", 32'(valid),  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
